bram_sdp_stream_fifo: RTL
=========================

// Module: bram_sdp_stream_fifo
// PURPOSE
//  Single-clock streaming FIFO whose storage is an inferred simple-dual-port BRAM (1 write port, 1 read port).
//  Generalises the plain SDP RAM to a valid/ready FIFO with parametrised width, depth and BRAM read latency.
//  A prefetch skid buffer hides the BRAM latency and sustains 1 word/cycle.
//  Used between NoC/AXI adapters on the FPGA build wherever distributed-RAM FIFOs are too large.
// PARAMETERS
//  WIDTH      64   data word width, bits (>=1)
//  DEPTH      512  total capacity in words, power of two, >=4
//  RD_LAT     2    BRAM read latency: 1 = no output register, 2 = BRAM output register
//  AF_THRESH  DEPTH-4  almost_full asserted when count >= AF_THRESH
//  AE_THRESH  4    almost_empty asserted when count <= AE_THRESH
// PORTS
//  clka          in   1                    clock; all logic on rising edge
//  rst           in   1                    asynchronous reset, active-high
//  s_data        in   WIDTH                write data
//  s_valid       in   1                    write request
//  s_ready       out  1                    FIFO can accept; registered, = (count != DEPTH)
//  m_data        out  WIDTH                head-of-FIFO data, valid while m_valid
//  m_valid       out  1                    head word available
//  m_ready       in   1                    consumer accepts head word
//  count         out  $clog2(DEPTH+1)      occupancy: BRAM + read pipeline + skid buffer
//  almost_full   out  1                    see AF_THRESH (BRAM_FIFO_STATUS_EN only)
//  almost_empty  out  1                    see AE_THRESH (BRAM_FIFO_STATUS_EN only)
// BEHAVIOUR
//  - Reset (async assert, sync-deasserted externally): wr_ptr=rd_ptr=0, count=0, s_ready=1, m_valid=0,
//    m_data=0, almost_full=0, almost_empty=1, read pipeline valids and skid buffer cleared. BRAM contents not cleared.
//  - Push = s_valid & s_ready; writes BRAM[wr_ptr], wr_ptr+1 mod DEPTH (natural wrap, ptr width $clog2(DEPTH)).
//  - Pop = m_valid & m_ready; removes skid-buffer head.
//  - count: +1 on push only, -1 on pop only, unchanged on both. s_ready is registered from next count.
//  - Prefetch: read issued when BRAM holds unread words (wr_ptr != rd_ptr, or tracked by ram_cnt)
//    and skid credits > 0; credits = RD_LAT+1 - (skid entries + reads in flight). Issue: rd_ptr+1.
//  - Skid buffer: RD_LAT+1 entries, FIFO ordered; BRAM output captured when its pipeline valid arrives.
//  - Latency: push on edge E0 -> m_valid high after edge E0+1+RD_LAT (2 cycles RD_LAT=1, 3 cycles RD_LAT=2).
//  - Throughput: continuous push+pop at full rate with zero bubbles once primed.
//  - Read/write same address same cycle cannot occur (reads only unread, already-written words).
//  - Full: s_ready=0 even if m_ready=1 that cycle; a push presented while full is ignored, no state change.
//  - Empty: m_valid=0; m_ready ignored; count never underflows.
//  - m_data/m_valid held stable while m_valid & !m_ready.
//  - Reset mid-operation: all in-flight and buffered words discarded; outputs return to reset values.
// CONFIGURATION
//  Macro BRAM_FIFO_STATUS_EN:
//   defined   -> almost_full/almost_empty registered, updated same edge as count, thresholds per parameters.
//   undefined -> no threshold compare logic; almost_full tied 0, almost_empty tied 0. count still present.
// TESTING
//  1 Reset: assert rst mid-traffic (count=7) -> same cycle m_valid=0, s_ready=1, count=0; next push of 0xA5 reads back 0xA5 only.
//  2 Latency: RD_LAT=2, single push 0x1234 at edge 0 -> m_valid rises after edge 3, m_data=0x1234; RD_LAT=1 -> after edge 2.
//  3 Fill: DEPTH=16, m_ready=0, push 0..15 -> s_ready=0 after 16th, count=16, 17th push ignored; drain yields 0..15 in order.
//  4 Streaming: s_valid=m_ready=1 for 1000 cycles, incrementing data -> no gaps after priming, output sequence exact, count constant.
//  5 Backpressure: random m_ready 30% duty, random s_valid, DEPTH=16 -> scoreboard match, pointers wrap >=10 times, no over/underflow.
//  6 Status (macro on, DEPTH=16, AF=12, AE=4): count 12 -> almost_full=1; count 4 -> almost_empty=1; count 5 -> almost_empty=0.

Source files
------------

// File: rtl/bram_sdp_stream_fifo.sv
// Single-clock valid/ready FIFO on an inferred simple-dual-port BRAM with a prefetch skid buffer.
// Optional almost_full/almost_empty status is built when BRAM_FIFO_STATUS_EN is defined.
module bram_sdp_stream_fifo #(
    parameter int unsigned WIDTH     = 64,
    parameter int unsigned DEPTH     = 512,
    parameter int unsigned RD_LAT    = 2,
    parameter int unsigned AF_THRESH = DEPTH - 4,
    parameter int unsigned AE_THRESH = 4
) (
    input  logic                       clka,
    input  logic                       rst,
    input  logic [WIDTH-1:0]           s_data,
    input  logic                       s_valid,
    output logic                       s_ready,
    output logic [WIDTH-1:0]           m_data,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       almost_full,
    output logic                       almost_empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned SK = RD_LAT + 1;
    localparam int unsigned SW = $clog2(SK + 1);

    generate
        if (RD_LAT < 1 || RD_LAT > 2 || DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0 ||
            AF_THRESH > DEPTH || AE_THRESH > DEPTH) begin : g_bad_cfg
            $error("bram_sdp_stream_fifo: unsupported parameter combination");
        end
    endgenerate

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] pipe_data [RD_LAT];
    logic [WIDTH-1:0] skid_data [SK];
    logic [WIDTH-1:0] skid_nxt  [SK];

    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [CW-1:0]     ram_cnt, count_nxt;
    logic [RD_LAT-1:0] pipe_vld;
    logic [SW-1:0]     skid_cnt, skid_cnt_nxt, skid_base, inflight, occ;
    logic              push, pop, issue, cap;

    assign push = s_valid && s_ready;
    assign pop  = m_valid && m_ready;
    assign cap  = pipe_vld[RD_LAT-1];

    // Words already committed to the skid buffer or still travelling through the BRAM pipeline.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < int'(RD_LAT); i++) begin
            inflight = inflight + SW'(pipe_vld[i]);
        end
        occ = skid_cnt + inflight;
    end

    // A pop this cycle frees a slot in time for a read issued now, keeping full rate.
    assign issue     = (ram_cnt != '0) && ((occ < SW'(SK)) || pop);
    assign count_nxt = count + CW'(push) - CW'(pop);

    // BRAM ports: no reset so the array and its output registers map onto block RAM.
    always_ff @(posedge clka) begin
        if (push) begin
            mem[wr_ptr] <= s_data;
        end
        if (issue) begin
            pipe_data[0] <= mem[rd_ptr];
        end
        for (int i = 1; i < int'(RD_LAT); i++) begin
            pipe_data[i] <= pipe_data[i-1];
        end
    end

    // Skid buffer is a short shift register; entry 0 is the head and drives m_data directly.
    always_comb begin
        skid_nxt     = skid_data;
        skid_base    = skid_cnt - SW'(pop);
        skid_cnt_nxt = skid_base + SW'(cap);
        if (pop) begin
            for (int i = 0; i < int'(SK) - 1; i++) begin
                skid_nxt[i] = skid_data[i+1];
            end
        end
        for (int i = 0; i < int'(SK); i++) begin
            if (cap && (SW'(i) == skid_base)) begin
                skid_nxt[i] = pipe_data[RD_LAT-1];
            end
        end
    end

    always_ff @(posedge clka or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            ram_cnt  <= '0;
            count    <= '0;
            s_ready  <= 1'b1;
            pipe_vld <= '0;
            skid_cnt <= '0;
            m_valid  <= 1'b0;
            for (int i = 0; i < int'(SK); i++) begin
                skid_data[i] <= '0;
            end
        end else begin
            wr_ptr   <= wr_ptr + AW'(push);
            rd_ptr   <= rd_ptr + AW'(issue);
            ram_cnt  <= ram_cnt + CW'(push) - CW'(issue);
            count    <= count_nxt;
            s_ready  <= (count_nxt != CW'(DEPTH));
            pipe_vld[0] <= issue;
            for (int i = 1; i < int'(RD_LAT); i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
            end
            skid_cnt  <= skid_cnt_nxt;
            skid_data <= skid_nxt;
            m_valid   <= (skid_cnt_nxt != '0);
        end
    end

    assign m_data = skid_data[0];

`ifdef BRAM_FIFO_STATUS_EN
    // Status flags track the same next-count value that loads count.
    always_ff @(posedge clka or posedge rst) begin
        if (rst) begin
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
        end else begin
            almost_full  <= (count_nxt >= CW'(AF_THRESH));
            almost_empty <= (count_nxt <= CW'(AE_THRESH));
        end
    end
`else
    assign almost_full  = 1'b0;
    assign almost_empty = 1'b0;
`endif

endmodule
